// File: rtl/gps_nco_pkg.sv
// gps_nco_pkg: shared widths and FSM state type for the
// time-multiplexed GPS carrier NCO scheduler.
package gps_nco_pkg;

    localparam int FREQ_W    = 62;
    localparam int ACC_W     = 63;
    localparam int PHASE_MSB = 62;
    localparam int PHASE_LSB = 59;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_e;

endpackage

// File: rtl/gps_carr_acc_bank.sv
// gps_carr_acc_bank: per-channel acc/freq/en register file, one
// shared phase adder and the registered result port.
// Ports: cfg_* write port, slot_vld_i/slot_i from the scheduler,
// out_* registered result of the slot executed last cycle.
import gps_nco_pkg::*;

module gps_carr_acc_bank #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [FREQ_W-1:0] cfg_freq_i,
    input  logic [ACC_W-1:0]  cfg_phase_i,
    input  logic              cfg_load_i,
    input  logic              cfg_en_i,
    input  logic              slot_vld_i,
    input  logic [CH_W-1:0]   slot_i,
    output logic              out_valid_o,
    output logic [CH_W-1:0]   out_ch_o,
    output logic [3:0]        out_phase_o,
    output logic [63:0]       out_acc_o
);

    logic [ACC_W-1:0]  acc_q  [NUM_CH];
    logic [FREQ_W-1:0] freq_q [NUM_CH];
    logic [NUM_CH-1:0] en_q;

    logic              out_valid_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [ACC_W-1:0]  out_acc_q;
    logic [ACC_W-1:0]  sum_d;

    // 63-bit sum: carry out of bit 62 is dropped, so phase wraps silently.
    assign sum_d = acc_q[slot_i] + {1'b0, freq_q[slot_i]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]  <= '0;
                freq_q[i] <= '0;
            end
            en_q        <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_acc_q   <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (cfg_we_i) begin
                freq_q[cfg_ch_i] <= cfg_freq_i;
                en_q[cfg_ch_i]   <= cfg_en_i;
                if (cfg_load_i) begin
                    acc_q[cfg_ch_i] <= cfg_phase_i;
                end
            end
            // Disabled slots still burn their cycle but leave no trace.
            if (slot_vld_i && en_q[slot_i]) begin
                acc_q[slot_i] <= sum_d;
                out_valid_q   <= 1'b1;
                out_ch_q      <= slot_i;
                out_acc_q     <= sum_d;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_ch_o    = out_ch_q;
    assign out_acc_o   = {1'b0, out_acc_q};
    assign out_phase_o = out_acc_q[PHASE_MSB:PHASE_LSB];

endmodule

// File: rtl/gps_carr_nco_sched.sv
// gps_carr_nco_sched: sweeps NUM_CH carrier NCO slots through one
// shared accumulator on every sample strobe.
// Ports: samp_stb starts a sweep; cfg_* valid/ready channel config;
// out_* per-slot result; busy/sweep_done/overrun status.
import gps_nco_pkg::*;

module gps_carr_nco_sched #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              samp_stb,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [FREQ_W-1:0] cfg_freq,
    input  logic [ACC_W-1:0]  cfg_phase,
    input  logic              cfg_load_phase,
    input  logic              cfg_en,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [3:0]        out_phase,
    output logic [63:0]       out_acc,
    output logic              busy,
    output logic              sweep_done,
    output logic              overrun
);

    localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);

    state_e          state_q;
    logic [CH_W-1:0] slot_q;
    logic            done_q;
    logic            overrun_q;
    logic            cfg_we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (samp_stb) begin
                        state_q <= SWEEP;
                        slot_q  <= '0;
                    end
                end
                SWEEP: begin
                    // Strobes inside a sweep are dropped, not queued.
                    if (samp_stb) begin
                        overrun_q <= 1'b1;
                    end
                    slot_q <= slot_q + CH_W'(1);
                    if (slot_q == LAST) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign cfg_ready  = rst && (state_q == IDLE);
    assign cfg_we     = cfg_valid && cfg_ready;
    assign busy       = (state_q == SWEEP);
    assign sweep_done = done_q;
    assign overrun    = overrun_q;

    gps_carr_acc_bank #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_bank (
        .clk         (clk),
        .rst         (rst),
        .cfg_we_i    (cfg_we),
        .cfg_ch_i    (cfg_ch),
        .cfg_freq_i  (cfg_freq),
        .cfg_phase_i (cfg_phase),
        .cfg_load_i  (cfg_load_phase),
        .cfg_en_i    (cfg_en),
        .slot_vld_i  (busy),
        .slot_i      (slot_q),
        .out_valid_o (out_valid),
        .out_ch_o    (out_ch),
        .out_phase_o (out_phase),
        .out_acc_o   (out_acc)
    );

endmodule

// File: doc/gps_carr_nco_sched.md
Name: gps_carr_nco_sched

Overview:
Time-division scheduler that shares one 63-bit carrier phase-accumulator datapath among NUM_CH tracking channels. Per-channel frequency words, phase state and enables live in a register bank loaded over a valid/ready config port. On each sample strobe the block sweeps all channel slots in fixed order and emits a 4-bit carrier phase per enabled channel. It sits between the tracking-loop firmware/loop filters and the per-channel carrier mixers.

Parameters:
NUM_CH, 4, number of time-multiplexed channels (power of 2, 2..16)
CH_W, $clog2(NUM_CH), channel index width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
samp_stb  in  1  one-cycle sample epoch strobe; starts a sweep
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when high with cfg_valid
cfg_ch  in  CH_W  target channel
cfg_freq  in  62  carrier frequency control word
cfg_phase  in  63  initial phase, used when cfg_load_phase=1
cfg_load_phase  in  1  overwrite channel accumulator with cfg_phase
cfg_en  in  1  channel enable written with the config
out_valid  out  1  out_ch/out_phase/out_acc valid this cycle
out_ch  out  CH_W  channel of the current result
out_phase  out  4  accumulator bits [62:59] after update
out_acc  out  64  zero-extended updated accumulator
busy  out  1  sweep in progress
sweep_done  out  1  one-cycle pulse with the last slot's result
overrun  out  1  sticky: samp_stb arrived while busy

Behaviour:
- Reset (rst=0 at posedge): FSM=IDLE; all acc, freq and enable entries 0; out_valid, busy, sweep_done and overrun 0; out_ch, out_phase and out_acc 0; cfg_ready 0 during reset.
- FSM has 2 states.
  - IDLE: cfg_ready=1. Any samp_stb moves to SWEEP with slot=0.
  - SWEEP: cfg_ready=0, busy=1. Slot increments every cycle. After slot NUM_CH-1, return to IDLE.
- Config write: a handshake occurs when cfg_valid && cfg_ready.
  - Writes freq[cfg_ch] and en[cfg_ch].
  - If cfg_load_phase=1, also writes acc[cfg_ch]={1'b0? no: acc[cfg_ch]=cfg_phase}; otherwise acc is preserved.
- Simultaneous cfg handshake and samp_stb in IDLE: the write commits first. The sweep starting next cycle uses the new values.
- Slot update for channel k, when en[k]=1:
  - acc[k] <= (acc[k][62:0] + freq[k]) mod 2^63, i.e. bit 63 is never set.
  - Wrap past 2^63-1 is silent and intended.
- Slot timing: slot k executes in cycle t+1+k, where t is the samp_stb cycle.
- Output registering: registered; out_valid=1 at cycle t+2+k with out_ch=k and the post-update values.
- Disabled channel:
  - The slot still consumes its cycle, so sweep timing stays fixed.
  - acc is held and out_valid=0 for that slot.
- sweep_done: pulses at t+1+NUM_CH, whether or not the last channel is enabled. busy falls in the same cycle.
- samp_stb during SWEEP: ignored, with no queuing. Sets overrun, which clears only on reset.
- Back-to-back sweeps: the minimum samp_stb spacing is NUM_CH+1 cycles. A strobe in the cycle the FSM returns to IDLE is accepted.
- Reset mid-sweep: the sweep aborts immediately and all state returns to reset values. No partial outputs are emitted afterwards.

Decomposition:
- Shared package gps_nco_pkg:
  - FREQ_W=62, ACC_W=63, PHASE_MSB=62, PHASE_LSB=59.
  - State enum {IDLE, SWEEP}.
- Sub-module gps_carr_acc_bank:
  - NUM_CH x (acc, freq, en) register file, plus the single shared adder and the output register.
  - The scheduler FSM drives its slot index and write-port controls.

Test Plan:
- Reset, then program ch0 with freq=2^59 and phase=0 (enabled), then pulse samp_stb → out_valid at t+2 with out_ch=0, out_phase=1; a second sweep gives out_phase=2.
- ch1 loaded with phase=2^63-2^59 and freq=2^59, one sweep → out_phase=0 and out_acc=0 (wrap), with no bit 63 set.
- Enable ch0 and ch2 only, NUM_CH=4 → out_valid high at t+2 and t+4 only; sweep_done at t+5; busy high t+1..t+4.
- cfg_valid and samp_stb in the same IDLE cycle writing freq=3 to ch0 (acc=0) → the sweep reports out_acc=3 for ch0; cfg_ready is low for the whole sweep.
- samp_stb at t+2 during a sweep → ignored, overrun=1 and remains 1 after later sweeps until rst=0.
- rst=0 at t+2 mid-sweep → next cycle out_valid=0, busy=0, and all acc reads back 0 on the next sweep.
